// File: rtl/ysyx_25060170_gpr_mp.sv
// ysyx_25060170_gpr_mp
//   Integer register file for the decode / write-back boundary.
//   - NRD combinational read ports with optional same-cycle write forwarding.
//   - One write-back port; register 0 is hardwired to zero.
//   - Per-register busy scoreboard: set at issue, cleared at write-back,
//     so decode can stall on RAW hazards.
//   - Dump engine streaming every register over a valid/ready handshake
//     to the difftest/trace side.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   rd_addr/rd_data/rd_busy  packed read ports, port i at slice i
//   we/waddr/wdata           write-back port
//   issue_valid/issue_rd     destination register of the issued instruction
//   dump_start               start a full dump (sampled in IDLE only)
//   dump_valid/dump_ready    dump beat handshake
//   dump_idx/dump_data       index and value of the current beat
//   dump_last                current beat is register NREG-1
//   dump_busy                dump engine running
module ysyx_25060170_gpr_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                dump_start,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_last,
    output logic                dump_busy
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;

    state_e          state_q, state_d;
    logic [AW-1:0]   dump_idx_q, dump_idx_d;
    logic [XLEN-1:0] dump_data_q, dump_data_d;
    logic            dump_valid_q, dump_valid_d;
    logic            dump_last_q, dump_last_d;
    logic [AW-1:0]   nxt_idx;

    logic wr_en;
    assign wr_en = we && (waddr != '0);

    // Read ports: a matching same-cycle write is forwarded, and its busy bit
    // is hidden because the value is already available.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          fwd;
            a   = rd_addr[i*AW +: AW];
            fwd = (BYPASS != 0) && wr_en && (waddr == a);
            rd_data[i*XLEN +: XLEN] = fwd ? wdata : regs_q[a];
            rd_busy[i]              = busy_q[a] && !fwd;
        end
    end

    // Register array and scoreboard next state. The set is applied after
    // the clear so a new producer keeps ownership of the register.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Dump engine. Each beat snapshots the stored value when it is loaded,
    // so later writes to that register do not disturb the held beat.
    always_comb begin
        state_d      = state_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        nxt_idx      = dump_idx_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d      = S_RUN;
                    dump_idx_d   = '0;
                    dump_data_d  = '0;
                    dump_valid_d = 1'b1;
                    dump_last_d  = (NREG == 1);
                end
            end
            S_RUN: begin
                if (dump_valid_q && dump_ready) begin
                    if (dump_last_q) begin
                        state_d      = S_IDLE;
                        dump_valid_d = 1'b0;
                        dump_last_d  = 1'b0;
                    end else begin
                        dump_idx_d  = nxt_idx;
                        dump_data_d = regs_q[nxt_idx];
                        dump_last_d = (nxt_idx == AW'(NREG - 1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_last_q;
    assign dump_busy  = (state_q == S_RUN);

endmodule
